muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 34 +++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/response bundle for the iterative multiply/divide unit.
//
// Request side : in_valid, in_ready, op[2:0], A, B, in_tag, kill
// Response side: out_valid, out_ready, result, out_tag
//
// Modports:
//   master -- the issuing pipeline (drives operations, consumes results)
//   slave  -- the muldiv_unit itself
interface muldiv_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [TAG_W-1:0]  in_tag;
    logic              kill;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, op, A, B, in_tag, kill, out_ready,
        input  in_ready, out_valid, result, out_tag
    );

    modport slave (
        input  in_valid, op, A, B, in_tag, kill, out_ready,
        output in_ready, out_valid, result, out_tag
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- RISC-V style M-extension multiply/divide unit.
//
// Multiplies use a one-bit-per-cycle shift-add on operand magnitudes; divides
// use one-bit-per-cycle restoring division on magnitudes. Signs are applied
// when the final result is written. Division by zero and signed overflow are
// resolved at acceptance and go straight to DONE.
//
// Ports:
//   clk   -- clock, all state on rising edge
//   reset -- asynchronous active-high reset
//   bus   -- muldiv_unit_if.slave: in_valid/in_ready/op/A/B/in_tag/kill,
//            out_valid/out_ready/result/out_tag
//
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiplier
// with a single-cycle combinational product computed at acceptance.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_nx;

    logic              in_ready, out_valid, accept, last_step;
    logic [DATA_W-1:0] hi_q, lo_q, mcand_q, result_q;
    logic [TAG_W-1:0]  tag_q;
    logic [1:0]        op_q;
    logic              neg_q, rem_neg_q;
    logic [CNT_W-1:0]  cnt_q;

    // ---------------- operand decode at acceptance ----------------
    logic              div_zero, div_ovf, sa, sb;
    logic [DATA_W-1:0] mag_a, mag_b;

    always_comb begin
        div_zero = (bus.B == '0);
        div_ovf  = !bus.op[0] && (bus.A == MIN_NEG) && (bus.B == '1);
        if (bus.op[2]) begin
            sa = !bus.op[0] && bus.A[DATA_W-1];
            sb = !bus.op[0] && bus.B[DATA_W-1];
        end else begin
            // MULH: both signed, MULHSU: only A signed; MUL low half is sign-agnostic
            sa = ((bus.op[1:0] == 2'b01) || (bus.op[1:0] == 2'b10)) && bus.A[DATA_W-1];
            sb = (bus.op[1:0] == 2'b01) && bus.B[DATA_W-1];
        end
        mag_a = sa ? -bus.A : bus.A;
        mag_b = sb ? -bus.B : bus.B;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
    logic [DATA_W-1:0]   fast_res;

    always_comb begin
        // sa/sb already encode "signed and negative", so they are the extension bits
        ext_a     = {{DATA_W{sa}}, bus.A};
        ext_b     = {{DATA_W{sb}}, bus.B};
        fast_prod = ext_a * ext_b;
        fast_res  = (bus.op[1:0] == 2'b00) ? fast_prod[DATA_W-1:0]
                                           : fast_prod[2*DATA_W-1:DATA_W];
    end
`endif

    // ---------------- one iteration step + final sign fix-up ----------------
    logic [DATA_W:0]     mul_sum, div_shift;
    logic [DATA_W-1:0]   div_diff, hi_nx, lo_nx, quo, rem, res_fin;
    logic                div_ge;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
        div_shift = {hi_q, lo_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        // only used when div_ge, so the true difference fits in DATA_W bits
        div_diff  = div_shift[DATA_W-1:0] - mcand_q;

        if (state == MUL) begin
            hi_nx = mul_sum[DATA_W:1];
            lo_nx = {mul_sum[0], lo_q[DATA_W-1:1]};
        end else begin
            hi_nx = div_ge ? div_diff : div_shift[DATA_W-1:0];
            lo_nx = {lo_q[DATA_W-2:0], div_ge};
        end

        prod = {hi_nx, lo_nx};
        if (neg_q) prod = -prod;
        quo = neg_q     ? -lo_nx : lo_nx;
        rem = rem_neg_q ? -hi_nx : hi_nx;

        if (state == MUL)
            res_fin = (op_q == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
        else
            res_fin = op_q[1] ? rem : quo;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE) && !bus.kill && !reset;
        out_valid = (state == DONE);
        accept    = bus.in_valid && in_ready;
        last_step = (cnt_q == CNT_W'(DATA_W-1));

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.op[2])
                        state_nx = (div_zero || div_ovf) ? DONE : DIV;
                    else
`ifdef MULDIV_FAST_MUL_EN
                        state_nx = DONE;
`else
                        state_nx = MUL;
`endif
                end
            end
            MUL, DIV: if (last_step) state_nx = DONE;
            DONE:     if (bus.out_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase

        if (bus.kill) state_nx = IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.op[1:0];
                        tag_q <= bus.in_tag;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        if (bus.op[2]) begin
                            neg_q     <= sa ^ sb;
                            rem_neg_q <= sa;
                            lo_q      <= mag_a;
                            mcand_q   <= mag_b;
                            if (div_zero)
                                result_q <= bus.op[1] ? bus.A : '1;
                            else if (div_ovf)
                                result_q <= bus.op[1] ? '0 : bus.A;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result_q <= fast_res;
`else
                            neg_q   <= sa ^ sb;
                            lo_q    <= mag_b;
                            mcand_q <= mag_a;
`endif
                        end
                    end
                end
                MUL, DIV: begin
                    hi_q  <= hi_nx;
                    lo_q  <= lo_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) result_q <= res_fin;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.out_tag   = tag_q;
endmodule
